// File: rtl/writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// writeback_stage_pkg
//   Shared definitions for the writeback stage and its lane filter:
//   - DATA_W_DEF / ADDR_W_DEF : default register data / index widths
//   - EXP_NONE                : exception code meaning "no exception"
//   - wb_state_e              : writeback FSM state encoding
//   - retire_count()          : number of instructions retiring this cycle
// -----------------------------------------------------------------------------
package writeback_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int EXP_NONE   = 0;

    // RUN: normal retirement. EXC_HOLD: an exception was reported and the
    // stage waits for the flush that follows it, writing nothing meanwhile.
    typedef enum logic {
        WB_RUN      = 1'b0,
        WB_EXC_HOLD = 1'b1
    } wb_state_e;

    function automatic logic [1:0] retire_count(input logic ok0, input logic ok1);
        return {1'b0, ok0} + {1'b0, ok1};
    endfunction

endpackage

// File: rtl/wb_lane_filter.sv
// -----------------------------------------------------------------------------
// wb_lane_filter
//   Purely combinational qualifier for one execution lane.
//   Ports:
//     en_i      lane result valid
//     rd_i      destination register
//     exp_i     exception code (EXP_NONE = no exception)
//     squash_i  an older instruction faulted; this lane is discarded
//     ok_o      lane retires (valid, no exception, not squashed)
//     fault_o   lane carries an exception and is not squashed
//     wr_o      lane retires and targets a real register (rd != 0)
// -----------------------------------------------------------------------------
module wb_lane_filter
    import writeback_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int EXP_W  = 7
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic              squash_i,
    output logic              ok_o,
    output logic              fault_o,
    output logic              wr_o
);

    logic live;

    assign live    = en_i && !squash_i;
    assign fault_o = live && (exp_i != EXP_W'(EXP_NONE));
    assign ok_o    = live && (exp_i == EXP_W'(EXP_NONE));
    // r0 is hard-wired zero: the instruction retires but never writes.
    assign wr_o    = ok_o && (rd_i != '0);

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Final stage of the dual-issue pipeline. Drives the two register-file write
//   ports from the two execution lanes (lane 0 is older than lane 1), reports
//   the first faulting instruction precisely, and counts retired instructions.
//   All outputs are registered; inputs sampled at one edge appear after it.
//   Ports:
//     clk, rstn                clock, synchronous active-low reset
//     stall                    consume no input this cycle
//     flush                    pipeline flush; returns FSM to RUN
//     euN_en/rd/data/exp/pc    lane N result, N = 0, 1
//     write_en/addr/data_N     register-file write port N
//     exp_valid/code/pc        one-cycle precise exception report
//     retire_cnt               retired-instruction counter (wraps)
//     state_dbg                current FSM state (0 = RUN, 1 = EXC_HOLD)
//   Handshake: there is no backpressure. A lane result is taken on every edge
//   where rstn=1, flush=0 and stall=0; euN_en qualifies it as a real result.
// -----------------------------------------------------------------------------
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int EXP_W  = 7,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  logic              eu0_en,
    input  logic [ADDR_W-1:0] eu0_rd,
    input  logic [DATA_W-1:0] eu0_data,
    input  logic [EXP_W-1:0]  eu0_exp,
    input  logic [31:0]       eu0_pc,
    input  logic              eu1_en,
    input  logic [ADDR_W-1:0] eu1_rd,
    input  logic [DATA_W-1:0] eu1_data,
    input  logic [EXP_W-1:0]  eu1_exp,
    input  logic [31:0]       eu1_pc,
    output logic              write_en_0,
    output logic [ADDR_W-1:0] write_addr_0,
    output logic [DATA_W-1:0] write_data_0,
    output logic              write_en_1,
    output logic [ADDR_W-1:0] write_addr_1,
    output logic [DATA_W-1:0] write_data_1,
    output logic              exp_valid,
    output logic [EXP_W-1:0]  exp_code,
    output logic [31:0]       exp_pc,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              state_dbg
);

    // ------------------------------------------------------------------
    // Lane qualification. Lane 0's fault squashes the younger lane 1.
    // ------------------------------------------------------------------
    logic ok0, fault0, wr0;
    logic ok1, fault1, wr1;

    wb_lane_filter #(.ADDR_W(ADDR_W), .EXP_W(EXP_W)) u_lane0 (
        .en_i     (eu0_en),
        .rd_i     (eu0_rd),
        .exp_i    (eu0_exp),
        .squash_i (1'b0),
        .ok_o     (ok0),
        .fault_o  (fault0),
        .wr_o     (wr0)
    );

    wb_lane_filter #(.ADDR_W(ADDR_W), .EXP_W(EXP_W)) u_lane1 (
        .en_i     (eu1_en),
        .rd_i     (eu1_rd),
        .exp_i    (eu1_exp),
        .squash_i (fault0),
        .ok_o     (ok1),
        .fault_o  (fault1),
        .wr_o     (wr1)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    wb_state_e         state_q, state_d;
    logic              we0_q, we0_d;
    logic              we1_q, we1_d;
    logic [ADDR_W-1:0] wa0_q, wa0_d;
    logic [ADDR_W-1:0] wa1_q, wa1_d;
    logic [DATA_W-1:0] wd0_q, wd0_d;
    logic [DATA_W-1:0] wd1_q, wd1_d;
    logic              ev_q, ev_d;
    logic [EXP_W-1:0]  ecode_q, ecode_d;
    logic [31:0]       epc_q, epc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Both lanes writing the same register: the younger lane 1 wins.
    logic waw;
    assign waw = wr0 && wr1 && (eu0_rd == eu1_rd);

    always_comb begin
        // Defaults: enables and the exception pulse drop, everything else holds.
        state_d = state_q;
        we0_d   = 1'b0;
        we1_d   = 1'b0;
        wa0_d   = wa0_q;
        wa1_d   = wa1_q;
        wd0_d   = wd0_q;
        wd1_d   = wd1_q;
        ev_d    = 1'b0;
        ecode_d = ecode_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;

        if (flush) begin
            state_d = WB_RUN;
        end else if (!stall) begin
            // Address/data follow the lanes on every accepted cycle so the
            // bypass network always sees the most recent lane contents.
            wa0_d = eu0_rd;
            wa1_d = eu1_rd;
            wd0_d = eu0_data;
            wd1_d = eu1_data;

            if (state_q == WB_RUN) begin
                we0_d = wr0 && !waw;
                we1_d = wr1;
                cnt_d = cnt_q + CNT_W'(retire_count(ok0, ok1));

                if (fault0) begin
                    ev_d    = 1'b1;
                    ecode_d = eu0_exp;
                    epc_d   = eu0_pc;
                    state_d = WB_EXC_HOLD;
                end else if (fault1) begin
                    ev_d    = 1'b1;
                    ecode_d = eu1_exp;
                    epc_d   = eu1_pc;
                    state_d = WB_EXC_HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= WB_RUN;
            we0_q   <= 1'b0;
            we1_q   <= 1'b0;
            wa0_q   <= '0;
            wa1_q   <= '0;
            wd0_q   <= '0;
            wd1_q   <= '0;
            ev_q    <= 1'b0;
            ecode_q <= '0;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we0_q   <= we0_d;
            we1_q   <= we1_d;
            wa0_q   <= wa0_d;
            wa1_q   <= wa1_d;
            wd0_q   <= wd0_d;
            wd1_q   <= wd1_d;
            ev_q    <= ev_d;
            ecode_q <= ecode_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign write_en_0   = we0_q;
    assign write_addr_0 = wa0_q;
    assign write_data_0 = wd0_q;
    assign write_en_1   = we1_q;
    assign write_addr_1 = wa1_q;
    assign write_data_1 = wd1_q;
    assign exp_valid    = ev_q;
    assign exp_code     = ecode_q;
    assign exp_pc       = epc_q;
    assign retire_cnt   = cnt_q;
    assign state_dbg    = state_q;

endmodule
